card_dealer: RTL and testbench

Parametrised card source for the BlackJack datapath. It supersedes the bare free-running 1–10 counter and the load latch.
- Keeps a free-running rank counter, plus per-rank remaining-card counts for a finite shoe.
- Serves draw requests through a req/valid handshake and never deals a depleted rank.
- Sits between the player/dealer control FSM and the score accumulators / HEX display.

---
 rtl/card_pkg.sv | 19 +
 rtl/rank_counter.sv | 19 +
 rtl/card_dealer.sv | 143 ++++++++++++++
 tb/tb_card_dealer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared types, default shoe geometry and the rank wrap helper for the card source.
package card_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    localparam int DEF_MIN_VAL   = 1;
    localparam int DEF_MAX_VAL   = 10;
    localparam int DEF_COPIES    = 4;
    localparam int DEF_FACE_MULT = 4;

    // Out-of-range values fold back to min_val so a corrupted rank self-recovers.
    function automatic int next_rank(input int v, input int min_val, input int max_val);
        return (v >= max_val || v < min_val) ? min_val : v + 1;
    endfunction

endpackage

// File: rtl/rank_counter.sv
// Free-running MIN_VAL..MAX_VAL wrap counter; the dealer samples it to pick a starting rank.
module rank_counter
    import card_pkg::*;
#(
    parameter int MIN_VAL = DEF_MIN_VAL,
    parameter int MAX_VAL = DEF_MAX_VAL,
    parameter int WIDTH   = 4
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] rank
);

    always_ff @(posedge clock) begin
        if (reset) rank <= WIDTH'(MIN_VAL);
        else       rank <= WIDTH'(next_rank(int'(rank), MIN_VAL, MAX_VAL));
    end

endmodule

// File: rtl/card_dealer.sv
// Finite-shoe card source with req/valid handshake; skips depleted ranks.
// Optional CARDS_LEFT_EN adds a running cards_left output that also drives empty.
//
// state  | meaning
// IDLE   | waiting for draw_req; empty shoe turns a request into draw_err
// SEARCH | probing remaining[probe], stepping to the next rank until stock is found
module card_dealer
    import card_pkg::*;
#(
    parameter int MIN_VAL   = DEF_MIN_VAL,
    parameter int MAX_VAL   = DEF_MAX_VAL,
    parameter int COPIES    = DEF_COPIES,
    parameter int FACE_MULT = DEF_FACE_MULT,
    parameter int WIDTH     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             draw_req,
    input  logic             shuffle,
    output logic [WIDTH-1:0] card,
    output logic             card_valid,
    output logic             draw_err,
    output logic             busy,
    output logic             empty
`ifdef CARDS_LEFT_EN
    ,
    output logic [$clog2(COPIES*(MAX_VAL-MIN_VAL)+COPIES*FACE_MULT+1)-1:0] cards_left
`endif
);

    localparam int CW    = $clog2(COPIES*FACE_MULT+1);
    localparam int TOTAL = COPIES*(MAX_VAL-MIN_VAL) + COPIES*FACE_MULT;
    localparam int LW    = $clog2(TOTAL+1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] rank, probe, probe_nx;
    logic [CW-1:0]    remaining [MIN_VAL:MAX_VAL];
    logic [CW-1:0]    probe_cnt;
    logic             take, err_nx;

    function automatic logic [CW-1:0] restock(input int r);
        return (r == MAX_VAL) ? CW'(COPIES*FACE_MULT) : CW'(COPIES);
    endfunction

    rank_counter #(
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL),
        .WIDTH   (WIDTH)
    ) u_rank_counter (
        .clock (clock),
        .reset (reset),
        .rank  (rank)
    );

    always_comb begin
        probe_cnt = '0;
        for (int r = MIN_VAL; r <= MAX_VAL; r++) begin
            if (probe == WIDTH'(r)) probe_cnt = remaining[r];
        end
    end

    always_comb begin
        state_nx = state;
        probe_nx = probe;
        take     = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (draw_req) begin
                    if (empty) begin
                        err_nx = 1'b1;
                    end else begin
                        probe_nx = rank;
                        state_nx = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (probe_cnt != '0) begin
                    take     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    probe_nx = WIDTH'(next_rank(int'(probe), MIN_VAL, MAX_VAL));
                end
            end
            default: state_nx = IDLE;
        endcase
        // Shuffle aborts any draw in flight and swallows a coincident request.
        if (shuffle) begin
            state_nx = IDLE;
            take     = 1'b0;
            err_nx   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            probe      <= WIDTH'(MIN_VAL);
            card       <= '0;
            card_valid <= 1'b0;
            draw_err   <= 1'b0;
        end else begin
            state      <= state_nx;
            probe      <= probe_nx;
            card_valid <= take;
            draw_err   <= err_nx;
            if (take) card <= probe;
        end
    end

    always_ff @(posedge clock) begin
        for (int r = MIN_VAL; r <= MAX_VAL; r++) begin
            if (reset || shuffle)
                remaining[r] <= restock(r);
            else if (take && probe == WIDTH'(r))
                remaining[r] <= remaining[r] - 1'b1;
        end
    end

    assign busy = (state == SEARCH);

`ifdef CARDS_LEFT_EN
    always_ff @(posedge clock) begin
        if (reset || shuffle) cards_left <= LW'(TOTAL);
        else if (take)        cards_left <= cards_left - 1'b1;
    end

    assign empty = (cards_left == '0);
`else
    logic any_stock;

    always_comb begin
        any_stock = 1'b0;
        for (int r = MIN_VAL; r <= MAX_VAL; r++) begin
            any_stock = any_stock | (remaining[r] != '0);
        end
    end

    assign empty = ~any_stock;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: table of targeted draws plus hand sequences for
// skip latency, depletion, draw_err, shuffle abort and reset during SEARCH.
module tb_card_dealer;

    logic       clock = 1'b0;
    logic       reset, draw_req, shuffle;
    logic [3:0] card;
    logic       card_valid, draw_err, busy, empty;
`ifdef CARDS_LEFT_EN
    logic [5:0] cards_left;
`endif

    int total_checks = 0;
    int passed       = 0;
    int ctr          = 0;   // expected rank counter value in the current cycle

    always #5 clock = ~clock;

    card_dealer dut (
        .clock      (clock),
        .reset      (reset),
        .draw_req   (draw_req),
        .shuffle    (shuffle),
        .card       (card),
        .card_valid (card_valid),
        .draw_err   (draw_err),
        .busy       (busy),
        .empty      (empty)
`ifdef CARDS_LEFT_EN
        ,
        .cards_left (cards_left)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        total_checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        ctr = reset ? 1 : ((ctr == 10) ? 1 : ctr + 1);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Pulse draw_req for one cycle now; lat counts cycles until card_valid.
    task automatic draw_any(output int got, output int lat);
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        lat = 1;
        while (!card_valid && lat < 20) begin
            tick();
            lat++;
        end
        got = card_valid ? int'(card) : -1;
    endtask

    task automatic draw_at(input int target, output int got, output int lat);
        int guard;
        guard = 0;
        while (ctr != target && guard < 12) begin
            tick();
            guard++;
        end
        draw_any(got, lat);
    endtask

    task automatic run_full_shoe(input string tag);
        int tally [1:10];
        int got, lat, bad;
        bad = 0;
        for (int v = 1; v <= 10; v++) tally[v] = 0;
        for (int i = 0; i < 52; i++) begin
            draw_any(got, lat);
            if (got >= 1 && got <= 10) tally[got]++;
            else bad++;
            if (i == 50) check({tag, " empty_before_last"}, int'(empty), 0);
        end
        check({tag, " empty_after_52"}, int'(empty), 1);
        check({tag, " missing_cards"}, bad, 0);
        for (int v = 1; v <= 10; v++)
            check($sformatf("%s tally_%0d", tag, v), tally[v], (v == 10) ? 16 : 4);
`ifdef CARDS_LEFT_EN
        check({tag, " cards_left_zero"}, int'(cards_left), 0);
`endif
    endtask

    typedef struct {
        int target;
        int exp_card;
        int exp_lat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int got, lat, ok, nvalid, last;

        // Targeted draws following the 7 from the first hand sequence.
        vecs[0] = '{3, 3, 2};
        vecs[1] = '{3, 3, 2};
        vecs[2] = '{3, 3, 2};
        vecs[3] = '{3, 3, 2};
        vecs[4] = '{3, 4, 3};   // rank 3 depleted, one skip
        vecs[5] = '{3, 4, 3};
        vecs[6] = '{1, 1, 2};
        vecs[7] = '{5, 5, 2};

        reset = 1'b1; draw_req = 1'b0; shuffle = 1'b0;
        tick();
        do_reset();

        check("reset card", int'(card), 0);
        check("reset card_valid", int'(card_valid), 0);
        check("reset draw_err", int'(draw_err), 0);
        check("reset busy", int'(busy), 0);
        check("reset empty", int'(empty), 0);
`ifdef CARDS_LEFT_EN
        check("reset cards_left", int'(cards_left), 52);
`endif

        // Single draw at counter 7: busy one cycle, card_valid at t+2.
        while (ctr != 7) tick();
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        check("t1 busy", int'(busy), 1);
        check("t1 early valid", int'(card_valid), 0);
        tick();
        check("t1 valid", int'(card_valid), 1);
        check("t1 card", int'(card), 7);
        check("t1 busy_after", int'(busy), 0);
        tick();
        check("t1 valid_pulse", int'(card_valid), 0);
        check("t1 card_held", int'(card), 7);

        for (int i = 0; i < 8; i++) begin
            draw_at(vecs[i].target, got, lat);
            check($sformatf("vec%0d card", i), got, vecs[i].exp_card);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
        end
`ifdef CARDS_LEFT_EN
        check("cards_left after table", int'(cards_left), 43);
`endif

        // Deplete rank 10, then wrap 10 -> 1.
        ok = 0;
        for (int i = 0; i < 16; i++) begin
            draw_at(10, got, lat);
            if (got == 10 && lat == 2) ok++;
        end
        check("deplete10 draws", ok, 16);
        draw_at(10, got, lat);
        check("wrap card", got, 1);
        check("wrap latency", lat, 3);

        // Deplete rank 1 too: probe 10 must skip 10 and 1.
        draw_at(1, got, lat);
        draw_at(1, got, lat);
        check("deplete1 last", got, 1);
        draw_at(10, got, lat);
        check("skip2 card", got, 2);
        check("skip2 latency", lat, 4);

        // draw_req held through SEARCH must not queue a second draw.
        while (ctr != 5) tick();
        draw_req = 1'b1;
        tick();
        tick();
        draw_req = 1'b0;
        check("hold valid", int'(card_valid), 1);
        check("hold card", int'(card), 5);
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (card_valid || busy) nvalid++;
        end
        check("hold no_second_draw", nvalid, 0);

        // Reset while in SEARCH.
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        check("rst_mid busy_before", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid busy", int'(busy), 0);
        check("rst_mid card", int'(card), 0);
        check("rst_mid valid", int'(card_valid), 0);
        check("rst_mid empty", int'(empty), 0);
`ifdef CARDS_LEFT_EN
        check("rst_mid cards_left", int'(cards_left), 52);
`endif
        draw_any(got, lat);
        check("rst_mid counter_restart", got, 1);
        check("rst_mid latency", lat, 2);

        // Whole shoe, then a request on the empty shoe.
        do_reset();
        run_full_shoe("shoe1");
        last = int'(card);
        tick();
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        check("empty draw_err", int'(draw_err), 1);
        check("empty no_valid", int'(card_valid), 0);
        check("empty busy", int'(busy), 0);
        check("empty card_held", int'(card), last);
        tick();
        check("empty draw_err_pulse", int'(draw_err), 0);

        // Shuffle coincident with draw_req: request dropped, shoe restocked.
        draw_req = 1'b1;
        shuffle  = 1'b1;
        tick();
        draw_req = 1'b0;
        shuffle  = 1'b0;
        check("shuf+req empty", int'(empty), 0);
        check("shuf+req busy", int'(busy), 0);
        check("shuf+req draw_err", int'(draw_err), 0);
        tick();
        check("shuf+req no_valid", int'(card_valid), 0);
        check("shuf+req card_held", int'(card), last);

        // Shuffle during SEARCH aborts the draw.
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        check("shuf_mid busy_before", int'(busy), 1);
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        check("shuf_mid busy", int'(busy), 0);
        check("shuf_mid no_valid", int'(card_valid), 0);
        tick();
        check("shuf_mid no_valid_late", int'(card_valid), 0);
        check("shuf_mid card_held", int'(card), last);
`ifdef CARDS_LEFT_EN
        check("shuf_mid cards_left", int'(cards_left), 52);
`endif

        run_full_shoe("shoe2");

        $display("%0d/%0d checks passed", passed, total_checks);
        $finish;
    end

endmodule
